hsstlp_rxlane_rst_fsm: RTL and testbench

Per-lane receive-side reset sequencer for the HSSTLP transceiver, paired with the TX lane reset FSM in the reset controller. It runs on the free-running clock. It handles four jobs:
- powering up the RX lane and releasing the RX PMA reset;
- waiting for signal detect and CDR lock;
- releasing the RX PCS reset;
- recovering from loss of signal/lock and servicing RX clock-divider (rate) changes.

---
 rtl/hsstlp_rxrst_pkg.sv | 26 ++
 rtl/hsstlp_bit_sync.sv | 25 ++
 rtl/hsstlp_rxlane_rst_fsm.sv | 183 ++++++++++++++++++
 tb/tb_hsstlp_rxlane_rst_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsstlp_rxrst_pkg.sv
// Shared definitions for the HSSTLP RX lane reset sequencer.
//   rx_state_e      : 3-bit sequencer state encoding
//   *_val functions : delay counts in free-clock cycles, derived from the
//                     free clock frequency in MHz (f)
package hsstlp_rxrst_pkg;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_PMA      = 3'd1,
    RX_WAIT_SIG = 3'd2,
    RX_WAIT_CDR = 3'd3,
    RX_PCS      = 3'd4,
    RX_DONE     = 3'd5,
    RX_CKDIV    = 3'd6
  } rx_state_e;

  function automatic int pma_rst_val(input int f);   return 2 * f;      endfunction
  function automatic int pma_done_val(input int f);  return 3 * f;      endfunction
  function automatic int lock_stable(input int f);   return f;          endfunction
  function automatic int cdr_timeout(input int f);   return 5 * f;      endfunction
  function automatic int pcs_rst_val(input int f);   return f / 2;      endfunction
  function automatic int pcs_done_val(input int f);  return f / 2 + 32; endfunction
  function automatic int rate_set_val(input int f);  return f / 2;      endfunction
  function automatic int rate_done_val(input int f); return f;          endfunction

endpackage

// File: rtl/hsstlp_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module hsstlp_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/hsstlp_rxlane_rst_fsm.sv
// Per-lane RX reset sequencer: powers the lane, releases PMA reset, waits for
// signal detect and stable CDR lock, releases PCS reset, and recovers from
// loss of signal/lock or services RX divider (rate) change requests.
//   clk, rst_n        : free-running clock, asynchronous active-low reset
//   i_sigdet          : PMA signal detect (async)
//   i_cdr_lock        : CDR lock (async)
//   i_rx_rate_chng    : rate-change request level (async), rising edge acts
//   i_rxckdiv         : requested divider, captured with the request edge
//   P_RX_LANE_PD      : lane power-down
//   P_RX_PMA_RST      : PMA reset
//   P_PCS_RX_RST      : PCS reset
//   P_RX_RATE         : divider driven to the PMA
//   o_rxlane_done     : lane up
//   o_rxckdiv_done    : last rate change finished (sticky)
module hsstlp_rxlane_rst_fsm
  import hsstlp_rxrst_pkg::*;
#(
  parameter int          FREE_CLOCK_FREQ = 100,
  parameter logic [2:0]  P_LX_RX_CKDIV   = 3'd0,
  parameter int          CNTR_WIDTH      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sigdet,
  input  logic       i_cdr_lock,
  input  logic       i_rx_rate_chng,
  input  logic [2:0] i_rxckdiv,
  output logic       P_RX_LANE_PD,
  output logic       P_RX_PMA_RST,
  output logic       P_PCS_RX_RST,
  output logic [2:0] P_RX_RATE,
  output logic       o_rxlane_done,
  output logic       o_rxckdiv_done
);

  localparam logic [CNTR_WIDTH-1:0] PMA_RST_C   = CNTR_WIDTH'(pma_rst_val(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] PMA_DONE_C  = CNTR_WIDTH'(pma_done_val(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] LOCK_LAST_C = CNTR_WIDTH'(lock_stable(FREE_CLOCK_FREQ) - 1);
  localparam logic [CNTR_WIDTH-1:0] CDR_TO_C    = CNTR_WIDTH'(cdr_timeout(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] PCS_RST_C   = CNTR_WIDTH'(pcs_rst_val(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] PCS_DONE_C  = CNTR_WIDTH'(pcs_done_val(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] RATE_SET_C  = CNTR_WIDTH'(rate_set_val(FREE_CLOCK_FREQ));
  localparam logic [CNTR_WIDTH-1:0] RATE_DONE_C = CNTR_WIDTH'(rate_done_val(FREE_CLOCK_FREQ));

  logic sigdet_s, lock_s, rc_s;

  hsstlp_bit_sync u_sync_sigdet (.clk(clk), .rst_n(rst_n), .d(i_sigdet),       .q(sigdet_s));
  hsstlp_bit_sync u_sync_lock   (.clk(clk), .rst_n(rst_n), .d(i_cdr_lock),     .q(lock_s));
  hsstlp_bit_sync u_sync_rc     (.clk(clk), .rst_n(rst_n), .d(i_rx_rate_chng), .q(rc_s));

  rx_state_e             state;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [CNTR_WIDTH-1:0] lock_cnt;
  logic                  pending;
  logic [2:0]            rxckdiv_cap;
  logic                  rc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RX_IDLE;
      cntr           <= '0;
      lock_cnt       <= '0;
      pending        <= 1'b0;
      rxckdiv_cap    <= P_LX_RX_CKDIV;
      rc_d           <= 1'b0;
      P_RX_LANE_PD   <= 1'b1;
      P_RX_PMA_RST   <= 1'b1;
      P_PCS_RX_RST   <= 1'b1;
      P_RX_RATE      <= P_LX_RX_CKDIV;
      o_rxlane_done  <= 1'b0;
      o_rxckdiv_done <= 1'b0;
    end else begin
      rc_d <= rc_s;

      case (state)
        RX_IDLE: begin
          P_RX_LANE_PD   <= 1'b1;
          P_RX_PMA_RST   <= 1'b1;
          P_PCS_RX_RST   <= 1'b1;
          P_RX_RATE      <= P_LX_RX_CKDIV;
          o_rxlane_done  <= 1'b0;
          o_rxckdiv_done <= 1'b0;
          cntr           <= '0;
          state          <= RX_PMA;
        end

        RX_PMA: begin
          P_RX_LANE_PD <= 1'b0;
          if (cntr == PMA_RST_C) P_RX_PMA_RST <= 1'b0;
          if (cntr == PMA_DONE_C) begin
            cntr  <= '0;
            state <= RX_WAIT_SIG;
          end else begin
            cntr <= cntr + 1'b1;
          end
        end

        RX_WAIT_SIG: begin
          cntr     <= '0;
          lock_cnt <= '0;
          if (sigdet_s) state <= RX_WAIT_CDR;
        end

        // Loss of signal outranks a completing stability count; the
        // stability count restarts on any cycle with lock low.
        RX_WAIT_CDR: begin
          if (!sigdet_s) begin
            cntr  <= '0;
            state <= RX_WAIT_SIG;
          end else if (lock_s && lock_cnt == LOCK_LAST_C) begin
            cntr  <= '0;
            state <= RX_PCS;
          end else if (cntr == CDR_TO_C) begin
            P_RX_PMA_RST <= 1'b1;
            cntr         <= '0;
            state        <= RX_PMA;
          end else begin
            cntr     <= cntr + 1'b1;
            lock_cnt <= lock_s ? lock_cnt + 1'b1 : '0;
          end
        end

        RX_PCS: begin
          if (!sigdet_s || !lock_s) begin
            P_PCS_RX_RST <= 1'b1;
            cntr         <= '0;
            state        <= RX_WAIT_SIG;
          end else begin
            if (cntr == PCS_RST_C) P_PCS_RX_RST <= 1'b0;
            if (cntr == PCS_DONE_C) begin
              o_rxlane_done <= 1'b1;
              cntr          <= '0;
              state         <= RX_DONE;
            end else begin
              cntr <= cntr + 1'b1;
            end
          end
        end

        RX_DONE: begin
          if (!sigdet_s || !lock_s) begin
            o_rxlane_done <= 1'b0;
            P_PCS_RX_RST  <= 1'b1;
            cntr          <= '0;
            state         <= RX_WAIT_SIG;
          end else if (pending) begin
            pending        <= 1'b0;
            P_RX_PMA_RST   <= 1'b1;
            P_PCS_RX_RST   <= 1'b1;
            o_rxlane_done  <= 1'b0;
            o_rxckdiv_done <= 1'b0;
            cntr           <= '0;
            state          <= RX_CKDIV;
          end else begin
            o_rxlane_done <= 1'b1;
          end
        end

        RX_CKDIV: begin
          if (cntr == RATE_SET_C) P_RX_RATE <= rxckdiv_cap;
          if (cntr == RATE_DONE_C) begin
            P_RX_PMA_RST   <= 1'b0;
            o_rxckdiv_done <= 1'b1;
            cntr           <= '0;
            state          <= RX_WAIT_SIG;
          end else begin
            cntr <= cntr + 1'b1;
          end
        end

        default: state <= RX_IDLE;
      endcase

      // Placed after the state logic so a request edge landing on the very
      // cycle RX_CKDIV is entered stays pending instead of being dropped.
      if (state != RX_CKDIV && rc_s && !rc_d) begin
        pending     <= 1'b1;
        rxckdiv_cap <= i_rxckdiv;
      end
    end
  end

endmodule

// File: tb/tb_hsstlp_rxlane_rst_fsm.sv
// Bench for hsstlp_rxlane_rst_fsm at 100 MHz free clock, reset divider 1.
// Expected output events (signal, value, cycle relative to a reference point)
// are queued as stimulus is applied and drained as the DUT produces them.
module tb_hsstlp_rxlane_rst_fsm;

  logic       clk;
  logic       rst_n;
  logic       i_sigdet;
  logic       i_cdr_lock;
  logic       i_rx_rate_chng;
  logic [2:0] i_rxckdiv;
  logic       P_RX_LANE_PD;
  logic       P_RX_PMA_RST;
  logic       P_PCS_RX_RST;
  logic [2:0] P_RX_RATE;
  logic       o_rxlane_done;
  logic       o_rxckdiv_done;

  hsstlp_rxlane_rst_fsm #(
    .FREE_CLOCK_FREQ(100),
    .P_LX_RX_CKDIV  (3'd1),
    .CNTR_WIDTH     (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sigdet      (i_sigdet),
    .i_cdr_lock    (i_cdr_lock),
    .i_rx_rate_chng(i_rx_rate_chng),
    .i_rxckdiv     (i_rxckdiv),
    .P_RX_LANE_PD  (P_RX_LANE_PD),
    .P_RX_PMA_RST  (P_RX_PMA_RST),
    .P_PCS_RX_RST  (P_PCS_RX_RST),
    .P_RX_RATE     (P_RX_RATE),
    .o_rxlane_done (o_rxlane_done),
    .o_rxckdiv_done(o_rxckdiv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_rxlane_done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    int sel;
    int val;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   t0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int sig_val(input int sel);
    case (sel)
      0:       return int'(P_RX_LANE_PD);
      1:       return int'(P_RX_PMA_RST);
      2:       return int'(P_PCS_RX_RST);
      3:       return int'(o_rxlane_done);
      4:       return int'(o_rxckdiv_done);
      5:       return int'(P_RX_RATE);
      default: return -1;
    endcase
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      0:       return "lane_pd";
      1:       return "pma_rst";
      2:       return "pcs_rst";
      3:       return "rxlane_done";
      4:       return "rxckdiv_done";
      5:       return "rx_rate";
      default: return "?";
    endcase
  endfunction

  task automatic push(input int sel, input int val, input int at);
    exp_t e;
    e.sel = sel; e.val = val; e.at = at;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns the relative cycle at which the chosen
  // output first shows val, or -1 when the budget runs out.
  task automatic wait_evt(input int sel, input int val, input int limit, output int obs);
    int n;
    bit hit;
    n = 0; hit = 1'b0; obs = -1;
    while (!hit && n <= limit) begin
      if (sig_val(sel) == val) begin
        hit = 1'b1;
        obs = cyc - t0;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic wait_to(input int n);
    while ((cyc - t0) < n) @(negedge clk);
  endtask

  task automatic rebase();
    t0 = cyc;
  endtask

  task automatic do_reset(input logic sd, input logic lk);
    @(negedge clk);
    rst_n = 1'b0;
    i_sigdet = sd;
    i_cdr_lock = lk;
    i_rx_rate_chng = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_sigdet = 1'b1;
    i_cdr_lock = 1'b1;
    i_rx_rate_chng = 1'b0;
    i_rxckdiv = 3'd0;
    repeat (3) @(negedge clk);
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
    push(3, 0, 0); push(4, 0, 0); push(5, 1, 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (sig_val(e.sel) !== e.val) begin
        n_err++;
        $display("FAIL reset %s: got %0d want %0d", sname(e.sel), sig_val(e.sel), e.val);
      end
    end
  endtask

  task automatic test_bringup();
    int obs;
    exp_t e;
    do_reset(1'b1, 1'b1);
    push(0, 0, 2); push(1, 0, 202); push(2, 0, 454); push(3, 1, 486);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 2000, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL bringup %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
  endtask

  task automatic test_no_lock();
    int obs;
    int base;
    exp_t e;
    do_reset(1'b1, 1'b0);
    base = done_cnt;
    push(1, 0, 202); push(1, 1, 804); push(1, 0, 1005); push(1, 1, 1607);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 2000, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL no_lock %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
    n_vec++;
    if (done_cnt !== base || P_RX_LANE_PD !== 1'b0) begin
      n_err++;
      $display("FAIL no_lock done_cycles=%0d pd=%0d, want 0 and 0", done_cnt - base, P_RX_LANE_PD);
    end
  endtask

  task automatic test_lock_glitch();
    int obs;
    exp_t e;
    do_reset(1'b1, 1'b1);
    // Lock sampled low at edge 362 only, reaching the FSM while the
    // stability count reads 60.
    wait_to(361);
    i_cdr_lock = 1'b0;
    wait_to(362);
    i_cdr_lock = 1'b1;
    push(2, 0, 454 + 61); push(3, 1, 486 + 61);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 2000, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL lock_glitch %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
  endtask

  task automatic test_sig_loss();
    int obs;
    exp_t e;
    repeat (5) @(negedge clk);
    rebase();
    i_sigdet = 1'b0;
    push(3, 0, 3); push(2, 1, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 100, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL sig_loss %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
    repeat (20) @(negedge clk);
    rebase();
    i_sigdet = 1'b1;
    push(2, 0, 154); push(3, 1, 186);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 1000, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL sig_restore %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
  endtask

  task automatic test_rate_change();
    int bad;
    repeat (5) @(negedge clk);
    rebase();
    i_rxckdiv = 3'b010;
    i_rx_rate_chng = 1'b1;
    push(3, 0, 4); push(1, 1, 4); push(5, 2, 55);
    push(4, 1, 105); push(1, 0, 105); push(3, 1, 289);
    fork
      begin
        // Second request edge lands while the divider change is running.
        wait_to(10);
        i_rx_rate_chng = 1'b0;
        wait_to(20);
        i_rxckdiv = 3'b101;
        i_rx_rate_chng = 1'b1;
      end
      begin
        int obs;
        exp_t e;
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          wait_evt(e.sel, e.val, 1000, obs);
          n_vec++;
          if (obs !== e.at) begin
            n_err++;
            $display("FAIL rate_chg %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
          end
        end
      end
    join
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_rxckdiv_done !== 1'b1 || P_RX_RATE !== 3'd2 || o_rxlane_done !== 1'b1) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL rate_ignore_2nd: %0d disturbed cycles, want 0", bad);
    end
  endtask

  task automatic test_reset_in_ckdiv();
    int obs;
    int bad;
    exp_t e;
    rebase();
    i_rx_rate_chng = 1'b0;
    wait_to(5);
    rebase();
    i_rxckdiv = 3'd3;
    i_rx_rate_chng = 1'b1;
    wait_to(70);
    n_vec++;
    if (P_RX_RATE !== 3'd3 || P_RX_LANE_PD !== 1'b0) begin
      n_err++;
      $display("FAIL ckdiv_pre_rst rate=%0d pd=%0d, want 3 and 0", P_RX_RATE, P_RX_LANE_PD);
    end
    #2;
    rst_n = 1'b0;
    i_rx_rate_chng = 1'b0;
    #1;
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
    push(3, 0, 0); push(4, 0, 0); push(5, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (sig_val(e.sel) !== e.val) begin
        n_err++;
        $display("FAIL async_rst %s: got %0d want %0d", sname(e.sel), sig_val(e.sel), e.val);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    push(0, 0, 2); push(3, 1, 486);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_evt(e.sel, e.val, 2000, obs);
      n_vec++;
      if (obs !== e.at) begin
        n_err++;
        $display("FAIL post_rst %s=%0d at cycle %0d, want cycle %0d", sname(e.sel), e.val, obs, e.at);
      end
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_rxckdiv_done !== 1'b0 || P_RX_RATE !== 3'd1 || o_rxlane_done !== 1'b1) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL post_rst_no_ckdiv: %0d disturbed cycles, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_no_lock();
    test_lock_glitch();
    test_sig_loss();
    test_rate_change();
    test_reset_in_ckdiv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
